// File: rtl/sort_phase_scheduler.sv
// Moore sequencer for the odd-even transposition sort array: LOAD, then CMP/SEND/RECV per round, FINAL, DONE.
// Optional early termination on two consecutive clean rounds when SORT_EARLY_EXIT_EN is defined.
module sort_phase_scheduler #(
  parameter int DATA_NUM  = 8,
  parameter int ROUND_NUM = DATA_NUM,
  localparam int CNT_W    = $clog2(ROUND_NUM + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             swap_any,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] round_idx,
  output logic             write_enable,
  output logic             odd_cmp_en,
  output logic             even_cmp_en,
  output logic             odd_SL,
  output logic             odd_SR,
  output logic             even_SL,
  output logic             even_SR,
  output logic             odd_RL,
  output logic             odd_RR,
  output logic             even_RL,
  output logic             even_RR
);

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUND_NUM - 1);

  if (DATA_NUM < 4 || (DATA_NUM % 2) != 0 || ROUND_NUM < 2) begin : g_bad_cfg
    $error("sort_phase_scheduler: DATA_NUM must be even and >= 4, ROUND_NUM >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CMP, S_SEND, S_RECV, S_FINAL, S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] round_reg, round_next;
  logic             early_exit;

`ifdef SORT_EARLY_EXIT_EN
  // cur_clean_reg is the CMP-phase clean flag of the current round; RECV folds in its own sample.
  logic cur_clean_reg;
  logic prev_clean_reg;
  logic round_clean;

  assign round_clean = cur_clean_reg & ~swap_any;
  assign early_exit  = (round_reg != '0) && prev_clean_reg && round_clean;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_clean_reg  <= 1'b0;
      prev_clean_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_LOAD:  prev_clean_reg <= 1'b0;
        S_CMP:   cur_clean_reg  <= ~swap_any;
        S_RECV:  prev_clean_reg <= round_clean;
        default: ;
      endcase
    end
  end
`else
  logic unused_swap_any;
  assign unused_swap_any = swap_any;
  assign early_exit      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      round_reg <= '0;
    end else begin
      state_reg <= state_next;
      round_reg <= round_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    round_next = round_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_LOAD;
          round_next = '0;
        end
      end
      S_LOAD:  state_next = S_CMP;
      S_CMP:   state_next = S_SEND;
      S_SEND:  state_next = S_RECV;
      S_RECV: begin
        if (early_exit) begin
          state_next = S_DONE;
        end else if (round_reg == LAST_ROUND) begin
          state_next = S_FINAL;
        end else begin
          round_next = round_reg + CNT_W'(1);
          state_next = S_CMP;
        end
      end
      S_FINAL: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Even rounds exchange across odd->even boundaries, odd rounds across even->odd.
  always_comb begin
    busy         = (state_reg != S_IDLE);
    done         = (state_reg == S_DONE);
    write_enable = (state_reg == S_LOAD);
    odd_cmp_en   = (state_reg == S_CMP) || (state_reg == S_FINAL);
    even_cmp_en  = odd_cmp_en;
    odd_SR       = (state_reg == S_SEND) && !round_reg[0];
    even_SL      = odd_SR;
    even_SR      = (state_reg == S_SEND) && round_reg[0];
    odd_SL       = even_SR;
    odd_RR       = (state_reg == S_RECV) && !round_reg[0];
    even_RL      = odd_RR;
    even_RR      = (state_reg == S_RECV) && round_reg[0];
    odd_RL       = even_RR;
  end

  assign round_idx = round_reg;

endmodule

// File: tb/tb_sort_phase_scheduler.sv
// Bench for sort_phase_scheduler: timing-offset reference model, nominal vector table, directed and random sequences.
module tb_sort_phase_scheduler;

  localparam int DN = 8;
  localparam int RN = 8;
  localparam int CW = $clog2(RN + 1);

  // Output vector order: busy done we ocmp ecmp | oSL oSR eSL eSR | oRL oRR eRL eRR
  localparam logic [12:0] V_IDLE  = 13'b0_0_0_0_0_0000_0000;
  localparam logic [12:0] V_LOAD  = 13'b1_0_1_0_0_0000_0000;
  localparam logic [12:0] V_CMP   = 13'b1_0_0_1_1_0000_0000;
  localparam logic [12:0] V_SEND0 = 13'b1_0_0_0_0_0110_0000;
  localparam logic [12:0] V_SEND1 = 13'b1_0_0_0_0_1001_0000;
  localparam logic [12:0] V_RECV0 = 13'b1_0_0_0_0_0000_0110;
  localparam logic [12:0] V_RECV1 = 13'b1_0_0_0_0_0000_1001;
  localparam logic [12:0] V_DONE  = 13'b1_1_0_0_0_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic swap_any = 1'b0;
  logic busy, done, write_enable, odd_cmp_en, even_cmp_en;
  logic odd_SL, odd_SR, even_SL, even_SR, odd_RL, odd_RR, even_RL, even_RR;
  logic [CW-1:0] round_idx;

  sort_phase_scheduler #(.DATA_NUM(DN), .ROUND_NUM(RN)) dut (
    .clk(clk), .rst(rst), .start(start), .swap_any(swap_any),
    .busy(busy), .done(done), .round_idx(round_idx), .write_enable(write_enable),
    .odd_cmp_en(odd_cmp_en), .even_cmp_en(even_cmp_en),
    .odd_SL(odd_SL), .odd_SR(odd_SR), .even_SL(even_SL), .even_SR(even_SR),
    .odd_RL(odd_RL), .odd_RR(odd_RR), .even_RL(even_RL), .even_RR(even_RR)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_done_cyc = -1;

  // Reference model: position inside a sort is the offset t from the accepting cycle k.
  bit m_active = 0;
  int m_k = 0, m_done_t = 0, m_final_t = 0, m_last = 0, m_idle_round = 0;
  bit m_prev_clean = 0, m_cur_clean = 0;

  bit cap_on = 0;
  int cap_k = 0;
  logic [12:0]   cap_vec [0:39];
  logic [CW-1:0] cap_rnd [0:39];

  typedef struct {
    int            t;
    logic [12:0]   vec;
    logic [CW-1:0] rnd;
  } vec_rec_t;
  vec_rec_t tbl [14];

  function automatic logic [12:0] dut_vec();
    return {busy, done, write_enable, odd_cmp_en, even_cmp_en,
            odd_SL, odd_SR, even_SL, even_SR, odd_RL, odd_RR, even_RL, even_RR};
  endfunction

  function automatic void model_expect(output logic [12:0] v, output int r);
    int t;
    v = V_IDLE;
    r = m_idle_round;
    if (m_active && cyc > m_k) begin
      t = cyc - m_k;
      if (t == 1) begin
        v = V_LOAD; r = 0;
      end else if (t == m_done_t) begin
        v = V_DONE; r = m_last;
      end else if (t == m_final_t) begin
        v = V_CMP; r = m_last;
      end else begin
        r = (t - 2) / 3;
        case ((t - 2) % 3)
          0:       v = V_CMP;
          1:       v = (r % 2 == 0) ? V_SEND0 : V_SEND1;
          default: v = (r % 2 == 0) ? V_RECV0 : V_RECV1;
        endcase
      end
    end
  endfunction

  function automatic void model_update();
    int t;
    if (!rst) begin
      m_active = 0;
      m_idle_round = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_k = cyc; m_done_t = 3 + 3 * RN; m_final_t = 2 + 3 * RN;
        m_last = RN - 1; m_prev_clean = 0;
      end
    end else begin
      t = cyc - m_k;
`ifdef SORT_EARLY_EXIT_EN
      if (t >= 2 && t < m_final_t) begin
        if ((t - 2) % 3 == 0) m_cur_clean = !swap_any;
        if ((t - 2) % 3 == 2) begin
          m_cur_clean = m_cur_clean && !swap_any;
          if ((t - 2) / 3 >= 1 && m_prev_clean && m_cur_clean) begin
            m_done_t = t + 1; m_final_t = -1; m_last = (t - 2) / 3;
          end
          m_prev_clean = m_cur_clean;
        end
      end
`endif
      if (t == m_done_t) begin
        m_active = 0;
        m_idle_round = m_last;
      end
    end
  endfunction

  function automatic void check();
    logic [12:0] ev, av;
    int er;
    bit pair_a, pair_b, rpair_a, rpair_b;
    model_expect(ev, er);
    av = dut_vec();
    n_assert++;
    if (av !== ev || round_idx !== CW'(er)) begin
      n_fail++;
      $display("FAIL model cyc=%0d got vec=%b rnd=%0d expected vec=%b rnd=%0d", cyc, av, round_idx, ev, er);
    end
    pair_a  = odd_SR | even_SL;
    pair_b  = even_SR | odd_SL;
    rpair_a = odd_RR | even_RL;
    rpair_b = even_RR | odd_RL;
    n_assert++;
    if (((pair_a | pair_b) && (rpair_a | rpair_b)) || (pair_a && pair_b) || (rpair_a && rpair_b)) begin
      n_fail++;
      $display("FAIL exclusive cyc=%0d got send=%b%b recv=%b%b required at most one pair, not both kinds",
               cyc, pair_a, pair_b, rpair_a, rpair_b);
    end
    if (done === 1'b1) begin
      last_done_cyc = cyc;
      $display("txn: done at cycle %0d round_idx=%0d", cyc, round_idx);
    end
    if (cap_on && cyc - cap_k >= 0 && cyc - cap_k < 40) begin
      cap_vec[cyc - cap_k] = av;
      cap_rnd[cyc - cap_k] = round_idx;
    end
  endfunction

  task automatic step(input logic r_n, input logic s, input logic sw);
    @(negedge clk);
    check();
    rst = r_n;
    start = s;
    swap_any = sw;
    model_update();
    cyc++;
  endtask

  // mode 0: swap 0, 1: swap 1, 2: random, 3: dirty through round 3 only
  function automatic logic swap_for(int mode);
    int t;
    t = cyc - m_k;
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom_range(0, 1));
      default: return (t >= 2 && (t - 2) / 3 <= 3);
    endcase
  endfunction

  task automatic run_until_idle(input int start_mode, input int swap_mode, input bit rand_rst);
    int n;
    logic s, r_n;
    n = 0;
    while (m_active && n < 100) begin
      s   = (start_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(start_mode);
      r_n = rand_rst ? ($urandom_range(0, 199) != 0) : 1'b1;
      step(r_n, s, swap_for(swap_mode));
      n++;
    end
    if (m_active) begin
      n_assert++; n_fail++;
      $display("FAIL timeout cyc=%0d got still busy after %0d cycles required idle", cyc, n);
      m_active = 0;
    end
  endtask

  task automatic chk_latency(input string name, input int k, input int exp_lat);
    n_assert++;
    if (last_done_cyc - k != exp_lat) begin
      n_fail++;
      $display("FAIL %s got done at k+%0d required k+%0d", name, last_done_cyc - k, exp_lat);
    end
  endtask

  initial begin
    int k;
    tbl[0]  = '{0,  V_IDLE,  CW'(0)};
    tbl[1]  = '{1,  V_LOAD,  CW'(0)};
    tbl[2]  = '{2,  V_CMP,   CW'(0)};
    tbl[3]  = '{3,  V_SEND0, CW'(0)};
    tbl[4]  = '{4,  V_RECV0, CW'(0)};
    tbl[5]  = '{5,  V_CMP,   CW'(1)};
    tbl[6]  = '{6,  V_SEND1, CW'(1)};
    tbl[7]  = '{7,  V_RECV1, CW'(1)};
    tbl[8]  = '{23, V_CMP,   CW'(7)};
    tbl[9]  = '{24, V_SEND1, CW'(7)};
    tbl[10] = '{25, V_RECV1, CW'(7)};
    tbl[11] = '{26, V_CMP,   CW'(7)};
    tbl[12] = '{27, V_DONE,  CW'(7)};
    tbl[13] = '{28, V_IDLE,  CW'(7)};

    // reset held with start high, then released with start low
    repeat (3) step(1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0);

    // nominal sort captured and compared against the table
    cap_on = 1; cap_k = cyc; k = cyc;
    step(1'b1, 1'b1, 1'b1);
    run_until_idle(0, 1, 0);
    repeat (2) step(1'b1, 1'b0, 1'b1);
    cap_on = 0;
    chk_latency("nominal_latency", k, 27);
    for (int i = 0; i < 14; i++) begin
      n_assert++;
      if (cap_vec[tbl[i].t] !== tbl[i].vec || cap_rnd[tbl[i].t] !== tbl[i].rnd) begin
        n_fail++;
        $display("FAIL table t=%0d got vec=%b rnd=%0d required vec=%b rnd=%0d",
                 tbl[i].t, cap_vec[tbl[i].t], cap_rnd[tbl[i].t], tbl[i].vec, tbl[i].rnd);
      end
    end

    // start held high: back-to-back sorts
    k = cyc;
    step(1'b1, 1'b1, 1'b1);
    run_until_idle(1, 1, 0);
    chk_latency("b2b_first", k, 27);
    k = cyc;
    step(1'b1, 1'b1, 1'b1);
    chk_latency("b2b_gap", k, -1);
    run_until_idle(1, 1, 0);
    chk_latency("b2b_second", k, 27);
    step(1'b1, 1'b0, 1'b0);

    // abort at SEND of round 3, then a fresh sort
    k = cyc;
    step(1'b1, 1'b1, 1'b1);
    while (cyc - k < 12) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    k = cyc;
    step(1'b1, 1'b1, 1'b1);
    run_until_idle(0, 1, 0);
    chk_latency("after_abort", k, 27);

`ifdef SORT_EARLY_EXIT_EN
    step(1'b1, 1'b0, 1'b0);
    k = cyc;
    step(1'b1, 1'b1, 1'b0);
    run_until_idle(0, 0, 0);
    chk_latency("early_exit_clean", k, 8);
    step(1'b1, 1'b0, 1'b0);
    k = cyc;
    step(1'b1, 1'b1, 1'b1);
    run_until_idle(0, 3, 0);
    chk_latency("early_exit_round3_dirty", k, 20);
`endif

    // random starts with noisy start/swap and rare resets
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      run_until_idle(2, 2, 1);
    end
    repeat (3) step(1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion required $finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
